lsu_bus_responder: RTL and testbench

- Memory-mapped responder for the load/store unit's data-port request/response protocol; completes the slave end of the LSU bus.
- Serves word-addressed data RAM plus a small MMIO register window: LED register, scratch register and free-running cycle counter.
- Sits between the core's data port and on-chip storage; accepts one request at a time, inserts configurable wait states, returns a single response beat.

---
 rtl/lsu_bus_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_lsu_bus_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_responder.sv
// lsu_bus_responder
// Slave end of the LSU data-port bus. Accepts one request at a time, waits
// WAIT_STATES cycles, then returns a single response beat. Serves a word
// addressed RAM plus a 16-byte MMIO window (LED, scratch, cycle counter).
// Optional feature macro: LSU_BUS_CYCLE_COUNTER_EN adds the 64-bit cycle
// counter at MMIO offsets 0x8/0xC; without it those offsets read as zero.

module lsu_bus_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  led
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [3:0]  led_q, led_d;
    logic [31:0] scratch_q, scratch_d;

`ifdef LSU_BUS_CYCLE_COUNTER_EN
    logic [63:0] cycles_q, cycles_d;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    logic             enter_resp;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [3:0]       op_be;
    logic             misaligned;
    logic             ram_hit;
    logic             mmio_hit;
    logic [31:0]      mmio_off;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      mmio_rdata;
    logic [31:0]      cnt_lo;
    logic [31:0]      cnt_hi;
    logic             mem_we;

    // With zero wait states the response is decoded on the accept edge itself,
    // so the live request is used; otherwise the latched copy is used.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_be    = req_be;
        end else begin
            op_we    = we_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_be    = be_q;
        end
    end

    // Address decode: alignment, RAM range and MMIO window.
    always_comb begin
        misaligned = (op_addr[1:0] != 2'b00);
        ram_hit    = (op_addr < RAM_BYTES);
        mmio_off   = op_addr - MMIO_BASE;
        mmio_hit   = (mmio_off < 32'd16);
        ram_idx    = op_addr[IDX_W+1:2];
    end

`ifdef LSU_BUS_CYCLE_COUNTER_EN
    // Free-running counter, halves exposed separately (no tear protection).
    always_comb begin
        cycles_d = cycles_q + 64'd1;
        cnt_lo   = cycles_q[31:0];
        cnt_hi   = cycles_q[63:32];
    end
`else
    // Counter absent: its registers read as zero.
    always_comb begin
        cnt_lo = 32'd0;
        cnt_hi = 32'd0;
    end
`endif

    // MMIO read mux by word offset within the window.
    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_off[3:2])
            2'd0:    mmio_rdata = {28'd0, led_q};
            2'd1:    mmio_rdata = scratch_q;
            2'd2:    mmio_rdata = cnt_lo;
            default: mmio_rdata = cnt_hi;
        endcase
    end

    // FSM next-state plus the decode/store/capture performed on RESP entry.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        led_d      = led_q;
        scratch_d  = scratch_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            if (misaligned) begin
                err_d = 1'b1;
            end else if (ram_hit) begin
                if (op_we) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = mem[ram_idx];
                end
            end else if (mmio_hit) begin
                if (op_we) begin
                    if (mmio_off[3:2] == 2'd0) begin
                        if (op_be[0]) begin
                            led_d = op_wdata[3:0];
                        end
                    end else if (mmio_off[3:2] == 2'd1) begin
                        for (int i = 0; i < 4; i++) begin
                            if (op_be[i]) begin
                                scratch_d[8*i +: 8] = op_wdata[8*i +: 8];
                            end
                        end
                    end
                end else begin
                    rdata_d = mmio_rdata;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and register file update; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            wait_q    <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            led_q     <= 4'd0;
            scratch_q <= 32'd0;
`ifdef LSU_BUS_CYCLE_COUNTER_EN
            cycles_q  <= 64'd0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
`ifdef LSU_BUS_CYCLE_COUNTER_EN
            cycles_q  <= cycles_d;
`endif
        end
    end

    // RAM array is not reset; byte lanes written only under their enables.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign led       = led_q;

endmodule

// File: tb/tb_lsu_bus_responder.sv
// Testbench for lsu_bus_responder: directed transactions, a behavioural
// model of the RAM/MMIO contents and handshake timing, a per-cycle compare
// process, and literal expectations for the key scenarios.

module tb_lsu_bus_responder;

    localparam int          DEPTH = 64;
    localparam int          W     = 1;
    localparam logic [31:0] MB    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  led;

    lsu_bus_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(W),
        .MMIO_BASE  (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .led      (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] modelMem [DEPTH];
    logic [3:0]  ledCur;
    logic [31:0] scratchCur;
    bit          pendMem, pendLed, pendScr;
    int          pendIdx;
    logic [31:0] pendMemVal, pendScrVal;
    logic [3:0]  pendLedVal;

    // Current transaction timing and expected response
    bit          txnActive = 1'b0;
    int          accCyc = 0;
    int          relCyc = -1;
    logic [31:0] expRdata;
    logic        expErr;
    bit          expKnown;
    bit          cmpEnable = 1'b0;

    // Results of the latest transaction
    logic [31:0] lastRdata;
    logic        lastErr;
    int          lastLat;
    int          lastEntry;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, required, cyc);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal, input logic [3:0] be);
        logic [31:0] r;
        r = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = newVal[8*i +: 8];
        end
        return r;
    endfunction

    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] off;
        int idx;
        expRdata = 32'd0;
        expErr   = 1'b0;
        expKnown = 1'b1;
        pendMem  = 1'b0;
        pendLed  = 1'b0;
        pendScr  = 1'b0;
        off      = addr - MB;
        if (addr % 4 != 0) begin
            expErr = 1'b1;
        end else if (addr < 32'(DEPTH * 4)) begin
            idx = int'(addr / 4);
            if (we) begin
                pendMem    = 1'b1;
                pendIdx    = idx;
                pendMemVal = mergeBytes(modelMem[idx], wdata, be);
            end else begin
                expRdata = modelMem[idx];
            end
        end else if (addr >= MB && off < 32'd16) begin
            if (we) begin
                if (off == 32'd0 && be[0]) begin
                    pendLed    = 1'b1;
                    pendLedVal = wdata[3:0];
                end else if (off == 32'd4) begin
                    pendScr    = 1'b1;
                    pendScrVal = mergeBytes(scratchCur, wdata, be);
                end
            end else begin
                if (off == 32'd0) expRdata = {28'd0, ledCur};
                else if (off == 32'd4) expRdata = scratchCur;
                else begin
`ifdef LSU_BUS_CYCLE_COUNTER_EN
                    expKnown = 1'b0;
`else
                    expRdata = 32'd0;
`endif
                end
            end
        end else begin
            expErr = 1'b1;
        end
    endtask

    task automatic commitModel();
        if (pendMem) modelMem[pendIdx] = pendMemVal;
        if (pendLed) ledCur = pendLedVal;
        if (pendScr) scratchCur = pendScrVal;
        pendMem = 1'b0;
        pendLed = 1'b0;
        pendScr = 1'b0;
    endtask

    task automatic modelReset();
        txnActive  = 1'b0;
        pendMem    = 1'b0;
        pendLed    = 1'b0;
        pendScr    = 1'b0;
        ledCur     = 4'd0;
        scratchCur = 32'd0;
    endtask

    // One full transaction; hold = cycles rsp_ready stays low once valid.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int hold);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        predict(we, addr, wdata, be);
        accCyc    = cyc;
        relCyc    = -1;
        txnActive = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout addr=%0h actual=no response required=response", addr);
            txnActive = 1'b0;
            pendLed   = 1'b0;
            lastRdata = 'x;
            lastErr   = 1'bx;
            return;
        end
        lastLat   = cyc - (accCyc - 1);
        lastEntry = cyc;
        commitModel();
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        lastRdata = rsp_rdata;
        lastErr   = rsp_err;
        @(posedge clk);
        #1;
        relCyc    = cyc;
        rsp_ready = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    int   cmpC;
    bit   cmpResp, cmpBusy;
    logic [3:0] cmpLed;
    always @(negedge clk) begin
        if (cmpEnable) begin
            cmpC    = cyc;
            cmpBusy = txnActive && (cmpC >= accCyc) && (relCyc < 0 || cmpC < relCyc);
            cmpResp = txnActive && (cmpC >= accCyc + W) && (relCyc < 0 || cmpC < relCyc);
            checkOutput("req_ready", {63'd0, req_ready}, {63'd0, !cmpBusy});
            checkOutput("rsp_valid", {63'd0, rsp_valid}, {63'd0, cmpResp});
            if (cmpResp) begin
                checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, expErr});
                if (expKnown) checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, expRdata});
            end
            cmpLed = (pendLed && txnActive && cmpC >= accCyc + W) ? pendLedVal : ledCur;
            checkOutput("led", {60'd0, led}, {60'd0, cmpLed});
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] v1, v2;
    int e1, e2;

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = 'x;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        rsp_ready = 1'b0;
        #1;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("reset_rsp_err",   {63'd0, rsp_err},   64'd0);
        checkOutput("reset_led",       {60'd0, led},       64'd0);
        cmpEnable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Store then load, latency WAIT_STATES+1
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        checkOutput("store_latency", 64'(lastLat), 64'd2);
        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 0);
        checkOutput("load_latency", 64'(lastLat), 64'd2);
        checkOutput("load_0x10", {32'd0, lastRdata}, 64'hDEAD_BEEF);
        checkOutput("load_0x10_err", {63'd0, lastErr}, 64'd0);

        // Byte-enable merge
        applyStimulus(1'b1, 32'h14, 32'hAABB_CCDD, 4'hF, 0);
        applyStimulus(1'b1, 32'h14, 32'h1122_3344, 4'b0101, 1);
        applyStimulus(1'b0, 32'h14, 32'd0, 4'hF, 0);
        checkOutput("be_merge", {32'd0, lastRdata}, 64'hAA22_CC44);

        // Misaligned and out-of-range
        applyStimulus(1'b1, 32'h0, 32'h1234_5678, 4'hF, 0);
        applyStimulus(1'b0, 32'h6, 32'd0, 4'hF, 0);
        checkOutput("misaligned_err", {63'd0, lastErr}, 64'd1);
        checkOutput("misaligned_rdata", {32'd0, lastRdata}, 64'd0);
        applyStimulus(1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF, 0);
        checkOutput("oob_store_err", {63'd0, lastErr}, 64'd1);
        applyStimulus(1'b0, 32'h0, 32'd0, 4'hF, 0);
        checkOutput("word0_intact", {32'd0, lastRdata}, 64'h1234_5678);

        // LED register
        applyStimulus(1'b1, MB, 32'h5, 4'h1, 0);
        checkOutput("led_after_store", {60'd0, led}, 64'h5);
        applyStimulus(1'b1, MB, 32'hA, 4'b1110, 0);
        applyStimulus(1'b0, MB, 32'd0, 4'hF, 0);
        checkOutput("led_readback", {32'd0, lastRdata}, 64'h5);

        // Back-pressure: response held five cycles
        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 5);
        checkOutput("held_rdata", {32'd0, lastRdata}, 64'hDEAD_BEEF);

        // Scratch register with byte enables; load with be=0
        applyStimulus(1'b1, MB + 32'h4, 32'hCAFE_F00D, 4'hF, 0);
        applyStimulus(1'b1, MB + 32'h4, 32'h0000_00AB, 4'b0001, 0);
        applyStimulus(1'b0, MB + 32'h4, 32'd0, 4'h0, 0);
        checkOutput("scratch_be0_load", {32'd0, lastRdata}, 64'hCAFE_F0AB);

        // Counter offsets: writes accepted silently, beyond window errors
        applyStimulus(1'b1, MB + 32'h8, 32'hFFFF_FFFF, 4'hF, 0);
        checkOutput("cnt_write_err", {63'd0, lastErr}, 64'd0);
        applyStimulus(1'b0, MB + 32'h10, 32'd0, 4'hF, 0);
        checkOutput("unmapped_err", {63'd0, lastErr}, 64'd1);
        applyStimulus(1'b0, MB + 32'hC, 32'd0, 4'hF, 0);
        checkOutput("cnt_hi_err", {63'd0, lastErr}, 64'd0);

        applyStimulus(1'b0, MB + 32'h8, 32'd0, 4'hF, 0);
        v1 = lastRdata;
        e1 = lastEntry;
        repeat (7) @(negedge clk);
        applyStimulus(1'b0, MB + 32'h8, 32'd0, 4'hF, 0);
        v2 = lastRdata;
        e2 = lastEntry;
`ifdef LSU_BUS_CYCLE_COUNTER_EN
        checkOutput("cycle_delta", {32'd0, v2 - v1}, 64'(e2 - e1));
`else
        checkOutput("cycle_absent_lo", {32'd0, v1}, 64'd0);
        checkOutput("cycle_absent_lo2", {32'd0, v2}, 64'd0);
`endif

        // Reset during WAIT of a store
        applyStimulus(1'b1, 32'h20, 32'h1, 4'hF, 0);
        applyStimulus(1'b0, MB + 32'h4, 32'd0, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h99;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        predict(1'b1, 32'h20, 32'h99, 4'hF);
        accCyc    = cyc;
        relCyc    = -1;
        txnActive = 1'b1;
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("midrst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("midrst_rsp_err",   {63'd0, rsp_err},   64'd0);
        checkOutput("midrst_led",       {60'd0, led},       64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 32'h20, 32'd0, 4'hF, 0);
        checkOutput("abandoned_store", {32'd0, lastRdata}, 64'h1);
        applyStimulus(1'b0, MB + 32'h4, 32'd0, 4'hF, 0);
        checkOutput("scratch_after_rst", {32'd0, lastRdata}, 64'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
